// File: rtl/key_schedule_controller.sv
// Iterative Simon 32/64 key expansion: one 16-bit subkey per cycle into a
// 32-entry round-key store, with registered random-access reads for the rounds.
module key_schedule_controller #(
    parameter int unsigned NUM_KEYS    = 32,
    parameter logic [15:0] ROUND_CONST = 16'hFFFC,
    parameter logic [61:0] Z_SEQ       = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        flush,
    input  logic        rk_rd_en,
    input  logic [4:0]  rk_rd_addr,
    output logic [15:0] rk_rd_data,
    output logic        rk_rd_valid,
    output logic        rk_rd_miss,
    output logic        sched_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_count;
    logic [15:0] r_store [32];
    logic [15:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_rd_miss;

    logic        w_accept;
    logic        w_last;
    logic        w_rd_hit;
    logic [4:0]  w_idx_m1;
    logic [4:0]  w_idx_m3;
    logic [4:0]  w_idx_m4;
    logic [5:0]  w_z_idx;
    logic [15:0] w_km1;
    logic [15:0] w_km3;
    logic [15:0] w_km4;
    logic [15:0] w_tmp0;
    logic [15:0] w_tmp1;
    logic [15:0] w_new_key;

    assign w_accept = key_valid && key_ready && !flush;
    assign w_last   = (r_count == 6'(NUM_KEYS - 1));
    assign w_rd_hit = ({1'b0, rk_rd_addr} < r_count);

    // Operands are only meaningful in EXPAND, where count is 4..NUM_KEYS-1.
    assign w_idx_m1  = r_count[4:0] - 5'd1;
    assign w_idx_m3  = r_count[4:0] - 5'd3;
    assign w_idx_m4  = r_count[4:0] - 5'd4;
    assign w_z_idx   = 6'd61 - (r_count - 6'd4);
    assign w_km1     = r_store[w_idx_m1];
    assign w_km3     = r_store[w_idx_m3];
    assign w_km4     = r_store[w_idx_m4];
    assign w_tmp0    = {w_km1[2:0], w_km1[15:3]} ^ w_km3;
    assign w_tmp1    = w_tmp0 ^ {w_tmp0[0], w_tmp0[15:1]};
    assign w_new_key = ROUND_CONST ^ {15'd0, Z_SEQ[w_z_idx]} ^ w_km4 ^ w_tmp1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (key_valid) w_next_state = ST_EXPAND;
                ST_EXPAND:        if (w_last)    w_next_state = ST_DONE;
                default:                         w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        key_ready   = 1'b0;
        busy        = 1'b0;
        sched_valid = 1'b0;
        case (r_state)
            ST_IDLE:   key_ready = 1'b1;
            ST_EXPAND: busy      = 1'b1;
            ST_DONE: begin
                key_ready   = 1'b1;
                sched_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            // NOTE: the store is deliberately cleared by reset so no stale key material survives an abort.
            for (int i = 0; i < 32; i++) r_store[i] <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_miss  <= 1'b0;
        end else begin
            r_rd_valid <= rk_rd_en;
            r_rd_miss  <= rk_rd_en && !w_rd_hit;
            if (rk_rd_en) begin
                r_rd_data <= w_rd_hit ? r_store[rk_rd_addr] : 16'd0;
            end

            if (flush) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_store[0] <= key[15:0];
                r_store[1] <= key[31:16];
                r_store[2] <= key[47:32];
                r_store[3] <= key[63:48];
                r_count    <= 6'd4;
            end else if (r_state == ST_EXPAND) begin
                r_store[r_count[4:0]] <= w_new_key;
                r_count               <= r_count + 6'd1;
            end
        end
    end

    assign rk_rd_data  = r_rd_data;
    assign rk_rd_valid = r_rd_valid;
    assign rk_rd_miss  = r_rd_miss;

endmodule

// File: tb/tb_key_schedule_controller.sv
// Directed bench for key_schedule_controller: a default 32-key instance and an
// 8-key instance share stimulus; subkeys are checked against a software Simon model.
module tb_key_schedule_controller;

    localparam logic [61:0] Z     = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [63:0] KEY_A = 64'h1918_1110_0908_0100;
    localparam logic [63:0] KEY_B = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key;
    logic        key_valid;
    logic        flush;
    logic        rk_rd_en;
    logic [4:0]  rk_rd_addr;

    logic        key_ready, rk_rd_valid, rk_rd_miss, sched_valid, busy;
    logic [15:0] rk_rd_data;
    logic        key_ready8, rk_rd_valid8, rk_rd_miss8, sched_valid8, busy8;
    logic [15:0] rk_rd_data8;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] exp_k [32];
    logic [15:0] got_k [32];

    always #5 clk = ~clk;

    key_schedule_controller dut (
        .clk(clk), .rst(rst), .key(key), .key_valid(key_valid), .key_ready(key_ready),
        .flush(flush), .rk_rd_en(rk_rd_en), .rk_rd_addr(rk_rd_addr),
        .rk_rd_data(rk_rd_data), .rk_rd_valid(rk_rd_valid), .rk_rd_miss(rk_rd_miss),
        .sched_valid(sched_valid), .busy(busy)
    );

    key_schedule_controller #(.NUM_KEYS(8)) dut8 (
        .clk(clk), .rst(rst), .key(key), .key_valid(key_valid), .key_ready(key_ready8),
        .flush(flush), .rk_rd_en(rk_rd_en), .rk_rd_addr(rk_rd_addr),
        .rk_rd_data(rk_rd_data8), .rk_rd_valid(rk_rd_valid8), .rk_rd_miss(rk_rd_miss8),
        .sched_valid(sched_valid8), .busy(busy8)
    );

    function automatic logic [15:0] rotr(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    // Reference Simon 32/64 schedule; c = 0xFFFC is written as ~3.
    task automatic build_model(input logic [63:0] k);
        logic [15:0] t;
        for (int i = 0; i < 4; i++) exp_k[i] = k[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rotr(exp_k[i-1], 3) ^ exp_k[i-3];
            t = t ^ rotr(t, 1);
            exp_k[i] = ~exp_k[i-4] ^ t ^ 16'h0003 ^ {15'd0, Z[61-(i-4)]};
        end
    endtask

    function automatic logic [31:0] encrypt(input logic [31:0] pt);
        logic [15:0] x, y, t;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ got_k[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic read_entry(input logic [4:0] a);
        rk_rd_en   = 1'b1;
        rk_rd_addr = a;
        tick();
        rk_rd_en   = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (sched_valid) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic readback_all(input string tag);
        for (int a = 0; a < 32; a++) begin
            read_entry(5'(a));
            got_k[a] = rk_rd_data;
            tests_run++;
            if (rk_rd_data !== exp_k[a] || rk_rd_miss !== 1'b0 || rk_rd_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s entry %0d: got %h miss=%b valid=%b expected %h hit", tag, a,
                         rk_rd_data, rk_rd_miss, rk_rd_valid, exp_k[a]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; key = '0; key_valid = 1'b0; flush = 1'b0; rk_rd_en = 1'b0; rk_rd_addr = '0;
        #12;
        tests_run++;
        if ({key_ready, busy, sched_valid, rk_rd_valid, rk_rd_miss, rk_rd_data} !== {5'b10000, 16'h0} ||
            {key_ready8, busy8, sched_valid8, rk_rd_valid8, rk_rd_miss8, rk_rd_data8} !== {5'b10000, 16'h0}) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b busy=%b sv=%b v=%b m=%b d=%h expected 1 0 0 0 0 0000",
                     key_ready, busy, sched_valid, rk_rd_valid, rk_rd_miss, rk_rd_data);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int done_edge;
        build_model(KEY_A);
        key = KEY_A; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tests_run++;
        if ({busy, key_ready, sched_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL accept_state: got busy=%b rdy=%b sv=%b expected 1 0 0", busy, key_ready, sched_valid);
        end
        done_edge = -1;
        for (int k = 1; k <= 40 && done_edge < 0; k++) begin
            rk_rd_en   = (k == 1 || k == 2 || k == 5 || k == 8);
            rk_rd_addr = (k <= 2) ? 5'd4 : 5'd10;
            tick();
            rk_rd_en = 1'b0;
            if (k == 1 || k == 5) begin
                tests_run++;
                if ({rk_rd_valid, rk_rd_miss, rk_rd_data} !== {2'b11, 16'h0}) begin
                    tests_failed++;
                    $display("FAIL early_read_miss edge %0d: got v=%b m=%b d=%h expected 1 1 0000",
                             k, rk_rd_valid, rk_rd_miss, rk_rd_data);
                end
            end
            if (k == 2) begin
                tests_run++;
                if ({rk_rd_valid, rk_rd_miss, rk_rd_data} !== {2'b10, 16'h71C3}) begin
                    tests_failed++;
                    $display("FAIL entry4_hit: got v=%b m=%b d=%h expected 1 0 71c3",
                             rk_rd_valid, rk_rd_miss, rk_rd_data);
                end
            end
            if (k == 3) begin
                tests_run++;
                if ({rk_rd_valid, rk_rd_miss, rk_rd_data} !== {2'b00, 16'h71C3}) begin
                    tests_failed++;
                    $display("FAIL read_hold: got v=%b m=%b d=%h expected 0 0 71c3",
                             rk_rd_valid, rk_rd_miss, rk_rd_data);
                end
            end
            if (k == 8) begin
                tests_run++;
                if ({rk_rd_valid, rk_rd_miss, rk_rd_data} !== {2'b10, exp_k[10]}) begin
                    tests_failed++;
                    $display("FAIL entry10_hit: got v=%b m=%b d=%h expected 1 0 %h",
                             rk_rd_valid, rk_rd_miss, rk_rd_data, exp_k[10]);
                end
            end
            if (sched_valid) begin
                done_edge = k;
            end else begin
                tests_run++;
                if (busy !== 1'b1 || key_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL busy_during_expand edge %0d: got busy=%b rdy=%b expected 1 0", k, busy, key_ready);
                end
            end
        end
        tests_run++;
        if (done_edge !== 28 || busy !== 1'b0 || key_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_timing: got edge %0d busy=%b rdy=%b expected 28 0 1", done_edge, busy, key_ready);
        end
        readback_all("key_a");
        tests_run++;
        if (encrypt(32'h6565_6877) !== 32'hC69B_E9BB) begin
            tests_failed++;
            $display("FAIL simon_encrypt: got %h expected c69be9bb", encrypt(32'h6565_6877));
        end
    endtask

    task automatic test_back_to_back;
        int edges;
        key = KEY_A; key_valid = 1'b1;
        tick();
        key = KEY_B;
        edges = -1;
        for (int k = 1; k <= 40 && edges < 0; k++) begin
            tick();
            if (sched_valid) begin
                edges = k;
            end else begin
                tests_run++;
                if (key_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ready_in_expand edge %0d: got %b expected 0", k, key_ready);
                end
            end
        end
        tests_run++;
        if (edges !== 28) begin
            tests_failed++;
            $display("FAIL key_ignored_in_expand: got done edge %0d expected 28", edges);
        end
        tick();
        key_valid = 1'b0;
        tests_run++;
        if ({sched_valid, busy, key_ready} !== 3'b010) begin
            tests_failed++;
            $display("FAIL accept_from_done: got sv=%b busy=%b rdy=%b expected 0 1 0", sched_valid, busy, key_ready);
        end
        build_model(KEY_B);
        wait_done(edges);
        tests_run++;
        if (edges !== 28) begin
            tests_failed++;
            $display("FAIL key_b_done: got edge %0d expected 28", edges);
        end
        readback_all("key_b");
    endtask

    task automatic test_flush;
        int edges;
        key = KEY_A; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (11) tick();
        flush = 1'b1; key_valid = 1'b1; key = KEY_B;
        tick();
        flush = 1'b0; key_valid = 1'b0;
        tests_run++;
        if ({key_ready, busy, sched_valid, sched_valid8} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL flush_state: got rdy=%b busy=%b sv=%b sv8=%b expected 1 0 0 0",
                     key_ready, busy, sched_valid, sched_valid8);
        end
        read_entry(5'd2);
        tests_run++;
        if ({rk_rd_valid, rk_rd_miss, rk_rd_data, busy} !== {2'b11, 16'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL flush_read_miss: got v=%b m=%b d=%h busy=%b expected 1 1 0000 0",
                     rk_rd_valid, rk_rd_miss, rk_rd_data, busy);
        end
        build_model(KEY_A);
        key = KEY_A; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        wait_done(edges);
        tests_run++;
        if (edges !== 28) begin
            tests_failed++;
            $display("FAIL regen_after_flush: got done edge %0d expected 28", edges);
        end
        readback_all("regen");
    endtask

    task automatic test_async_reset;
        key = KEY_A; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
        tick();
        read_entry(5'd0);
        tick();
        tests_run++;
        if (rk_rd_data !== 16'h0100) begin
            tests_failed++;
            $display("FAIL pre_reset_read: got %h expected 0100", rk_rd_data);
        end
        #3 rst = 1'b0;
        #1;
        tests_run++;
        if ({key_ready, busy, sched_valid, rk_rd_valid, rk_rd_miss, rk_rd_data} !== {5'b10000, 16'h0}) begin
            tests_failed++;
            $display("FAIL async_reset: got rdy=%b busy=%b sv=%b v=%b m=%b d=%h expected 1 0 0 0 0 0000",
                     key_ready, busy, sched_valid, rk_rd_valid, rk_rd_miss, rk_rd_data);
        end
        #2 rst = 1'b1;
        tick();
        read_entry(5'd0);
        tests_run++;
        if ({rk_rd_valid, rk_rd_miss, rk_rd_data, key_ready, busy} !== {2'b11, 16'h0, 2'b10}) begin
            tests_failed++;
            $display("FAIL post_reset_read: got v=%b m=%b d=%h rdy=%b busy=%b expected 1 1 0000 1 0",
                     rk_rd_valid, rk_rd_miss, rk_rd_data, key_ready, busy);
        end
    endtask

    task automatic test_num_keys_8;
        int edges;
        build_model(KEY_A);
        key = KEY_A; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        edges = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (sched_valid8) begin
                edges = k;
                break;
            end
        end
        tests_run++;
        if (edges !== 4 || busy8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL nk8_done: got edge %0d busy=%b expected 4 0", edges, busy8);
        end
        read_entry(5'd7);
        tests_run++;
        if ({rk_rd_valid8, rk_rd_miss8, rk_rd_data8} !== {2'b10, exp_k[7]}) begin
            tests_failed++;
            $display("FAIL nk8_entry7: got v=%b m=%b d=%h expected 1 0 %h",
                     rk_rd_valid8, rk_rd_miss8, rk_rd_data8, exp_k[7]);
        end
        read_entry(5'd8);
        tests_run++;
        if ({rk_rd_valid8, rk_rd_miss8, rk_rd_data8} !== {2'b11, 16'h0}) begin
            tests_failed++;
            $display("FAIL nk8_entry8_miss: got v=%b m=%b d=%h expected 1 1 0000",
                     rk_rd_valid8, rk_rd_miss8, rk_rd_data8);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_num_keys_8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
